// File: rtl/fifo_rd_stream.sv
// Converts a FWFT-less FIFO read port (data one cycle after rd_en) into a valid/ready stream
// with PKT_LEN-beat o_last framing. Optional beat counter port under FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
    parameter int SIZE_DATA = 8,
    parameter int PKT_LEN   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_empty,
    output logic                 o_rd_en,
    input  logic [SIZE_DATA-1:0] i_data_rd,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_last
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [15:0]          o_count
`endif
);

    localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

    logic [SIZE_DATA-1:0] r_buf [4];
    logic [1:0]           r_wr_ptr;
    logic [1:0]           r_rd_ptr;
    logic [2:0]           r_occ;
    logic                 r_inflight;
    logic [7:0]           r_beat;

    logic                 w_hs;
    logic                 w_cap;
    logic [3:0]           w_pending;

    // A pop is only issued when the word it returns is guaranteed a free slot,
    // so the read strobe never depends on i_ready.
    assign w_pending = {1'b0, r_occ} + {3'b000, r_inflight};
    assign o_rd_en   = !i_empty && (w_pending <= 4'd3) && !i_rst;

    assign w_cap   = r_inflight;
    assign o_valid = (r_occ != 3'd0);
    assign w_hs    = o_valid && i_ready;
    assign o_data  = r_buf[r_rd_ptr];
    assign o_last  = o_valid && (r_beat == LAST_BEAT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) r_buf[i] <= '0;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_occ      <= 3'd0;
            r_inflight <= 1'b0;
            r_beat     <= 8'd0;
        end else begin
            r_inflight <= o_rd_en;
            if (w_cap) begin
                r_buf[r_wr_ptr] <= i_data_rd;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_hs) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
                r_beat   <= (r_beat == LAST_BEAT) ? 8'd0 : r_beat + 8'd1;
            end
            case ({w_cap, w_hs})
                2'b10:   r_occ <= r_occ + 3'd1;
                2'b01:   r_occ <= r_occ - 3'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst)     r_count <= 16'd0;
        else if (w_hs) r_count <= r_count + 16'd1;
    end

    assign o_count = r_count;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, popped words
// become expected beats, and a negedge monitor checks every accepted beat and its framing.
module tb_fifo_rd_stream;

    localparam int DW      = 8;
    localparam int PKT_LEN = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_empty;
    logic          o_rd_en;
    logic [DW-1:0] i_data_rd;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_last;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0]   o_count;
`endif

    fifo_rd_stream #(.SIZE_DATA(DW), .PKT_LEN(PKT_LEN)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_empty  (i_empty),
        .o_rd_en  (o_rd_en),
        .i_data_rd(i_data_rd),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_last   (o_last)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .o_count  (o_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fq[$];      // contents of the upstream FIFO
    logic [DW-1:0] exp_q[$];   // words popped but not yet delivered downstream
    logic [DW-1:0] hs_log[$];  // every accepted beat
    logic [DW-1:0] last_log[$];
    logic [DW-1:0] pend;
    logic          pend_v = 1'b0;
    logic          rst_req, rdy_req, hold_empty;
    int            pops = 0;
    int            hs   = 0;
    int            beat_m = 0;
    logic [15:0]   cnt_m = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the edge, then check strobe/valid and model the pop.
    task automatic step();
        logic exp_rd, exp_vld;
        @(posedge i_clk);
        #1;
        i_data_rd = pend_v ? pend : DW'($urandom);
        i_rst     = rst_req;
        i_ready   = rdy_req;
        i_empty   = hold_empty || (fq.size() == 0);
        #1;
        exp_rd  = !i_rst && !i_empty && (exp_q.size() <= 3);
        exp_vld = (exp_q.size() - (pend_v ? 1 : 0)) > 0;
        chk("rd_en", {31'd0, o_rd_en}, {31'd0, exp_rd});
        chk("valid", {31'd0, o_valid}, {31'd0, exp_vld});
        pend_v = 1'b0;
        if (o_rd_en && fq.size() != 0) begin
            pend   = fq.pop_front();
            pend_v = 1'b1;
            exp_q.push_back(pend);
            pops++;
        end
    endtask

    always @(negedge i_clk) begin
        if (i_rst === 1'b1) begin
            exp_q.delete();
            beat_m = 0;
            cnt_m  = 16'd0;
        end else begin
`ifdef FIFO_RD_STREAM_CNT_EN
            chk("count", {16'd0, o_count}, {16'd0, cnt_m});
`endif
            if (o_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", {31'd0, o_valid}, 32'd0);
                end else begin
                    chk("data", {24'd0, o_data}, {24'd0, exp_q[0]});
                    chk("last", {31'd0, o_last}, (beat_m == PKT_LEN - 1) ? 32'd1 : 32'd0);
                    if (i_ready === 1'b1) begin
                        hs_log.push_back(o_data);
                        if (o_last) last_log.push_back(o_data);
                        void'(exp_q.pop_front());
                        beat_m = (beat_m == PKT_LEN - 1) ? 0 : beat_m + 1;
                        cnt_m  = cnt_m + 16'd1;
                        hs++;
                    end
                end
            end
        end
    end

    task automatic drain(input string name);
        int n = 0;
        rdy_req    = 1'b1;
        hold_empty = 1'b0;
        while ((fq.size() != 0 || exp_q.size() != 0 || pend_v) && n < 300) begin
            step();
            n++;
        end
        step();
        chk({name, "_drained"}, exp_q.size() + fq.size(), 32'd0);
    endtask

    initial begin
        int hs0, pops0, n;
        logic [DW-1:0] nxt;
        i_rst = 1'b1; i_empty = 1'b1; i_ready = 1'b0; i_data_rd = '0;
        rst_req = 1'b1; rdy_req = 1'b0; hold_empty = 1'b0;

        // reset state
        step();
        chk("rst_rd_en", {31'd0, o_rd_en}, 32'd0);
        step();
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_data",  {24'd0, o_data},  32'd0);
        chk("rst_last",  {31'd0, o_last},  32'd0);
        rst_req = 1'b0;

        // first word: pop at N, valid at N+2, then gone
        rdy_req = 1'b1;
        fq.push_back(8'h01);
        step();
        chk("fw_rd_en_n", {31'd0, o_rd_en}, 32'd1);
        step();
        chk("fw_rd_en_n1", {31'd0, o_rd_en}, 32'd0);
        chk("fw_valid_n1", {31'd0, o_valid}, 32'd0);
        step();
        chk("fw_valid_n2", {31'd0, o_valid}, 32'd1);
        chk("fw_data_n2",  {24'd0, o_data},  32'h01);
        step();
        chk("fw_valid_n3", {31'd0, o_valid}, 32'd0);

        // streaming 32 words with a fresh beat counter
        for (int i = 1; i <= 32; i++) fq.push_back(DW'(i));
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        last_log.delete();
        hs0 = hs;
        for (int i = 0; i < 34; i++) step();
        @(negedge i_clk); #1;
        chk("stream_beats", hs - hs0, 32'd32);
        chk("stream_nlast", last_log.size(), 32'd2);
        if (last_log.size() == 2) begin
            chk("stream_last0", {24'd0, last_log[0]}, 32'h10);
            chk("stream_last1", {24'd0, last_log[1]}, 32'h20);
        end
        drain("stream");

        // backpressure: exactly four pops, data held, then release
        for (int i = 0; i < 10; i++) fq.push_back(DW'(8'h40 + i));
        rdy_req = 1'b0;
        pops0 = pops;
        for (int i = 0; i < 8; i++) step();
        chk("bp_pops",  pops - pops0, 32'd4);
        chk("bp_rd_en", {31'd0, o_rd_en}, 32'd0);
        chk("bp_hold",  {24'd0, o_data}, 32'h40);
        rdy_req = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("bp_resume", (pops - pops0 > 4) ? 32'd1 : 32'd0, 32'd1);
        drain("bp");

        // alternating ready over 20 words
        hs0 = hs;
        for (int i = 0; i < 20; i++) fq.push_back(DW'($urandom));
        n = 0;
        while ((fq.size() != 0 || exp_q.size() != 0) && n < 200) begin
            rdy_req = n[0] ? 1'b0 : 1'b1;
            step();
            n++;
        end
        drain("alt");
        chk("alt_beats", hs - hs0, 32'd20);

        // reset with three buffered and one in flight
        for (int i = 0; i < 10; i++) fq.push_back(DW'(8'h80 + i));
        rdy_req = 1'b0;
        pops0 = pops;
        n = 0;
        while (pops - pops0 < 4 && n < 20) begin
            step();
            n++;
        end
        chk("mr_setup", pops - pops0, 32'd4);
        nxt = fq[0];
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        chk("mr_valid", {31'd0, o_valid}, 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("mr_count", {16'd0, o_count}, 32'd0);
`endif
        hs_log.delete();
        drain("mr");
        chk("mr_next", (hs_log.size() != 0) ? {24'd0, hs_log[0]} : 32'hFFFF_FFFF, {24'd0, nxt});

        // empty FIFO for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step();
            chk("empty_rd_en", {31'd0, o_rd_en}, 32'd0);
            chk("empty_valid", {31'd0, o_valid}, 32'd0);
        end

        // randomized traffic with occasional reset
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 2) == 0) fq.push_back(DW'($urandom));
            rdy_req    = ($urandom_range(0, 9) < 7);
            hold_empty = ($urandom_range(0, 15) == 0);
            rst_req    = ($urandom_range(0, 199) == 0);
            step();
            if (hs_log.size() > 64) hs_log.delete();
            if (last_log.size() > 64) last_log.delete();
        end
        rst_req = 1'b0;
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter SIZE_DATA, default 8: data width in bits.
REQ-002 The block SHALL have parameter PKT_LEN, default 16: beats per packet for o_last framing (range 2..256).
REQ-003 The block SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port i_empty  input  1  FIFO read-side empty flag.
REQ-006 The block SHALL have port o_rd_en  output  1  FIFO read strobe; one pop per cycle high.
REQ-007 The block SHALL have port i_data_rd  input  SIZE_DATA  FIFO read data, valid the cycle after o_rd_en.
REQ-008 The block SHALL have port o_valid  output  1  stream data valid.
REQ-009 The block SHALL have port i_ready  input  1  downstream accepts the beat.
REQ-010 The block SHALL have port o_data  output  SIZE_DATA  stream data.
REQ-011 The block SHALL have port o_last  output  1  final beat of the current PKT_LEN-beat packet.

Function
REQ-012 The block SHALL hold a 4-entry circular buffer with 2-bit read/write pointers wrapping 3->0 and a 3-bit occupancy count (0..4).
REQ-013 The block SHALL keep a 1-bit in-flight flag, set in the cycle after o_rd_en=1, clear otherwise.
REQ-014 o_rd_en SHALL equal (!i_empty && occupancy + in_flight <= 3 && !i_rst), decoded from registers only; no combinational path from i_ready.
REQ-015 When in_flight=1, i_data_rd SHALL be written at the write pointer at that clock edge.
REQ-016 o_valid SHALL be 1 exactly when occupancy > 0; o_data SHALL be the entry at the read pointer.
REQ-017 A handshake (o_valid && i_ready) SHALL advance the read pointer; o_data and o_last SHALL stay stable while o_valid=1 and i_ready=0.
REQ-018 Simultaneous capture and handshake SHALL leave occupancy unchanged; both pointers advance.
REQ-019 First-word latency SHALL be 2 cycles: i_empty falls at cycle N with buffer empty -> o_rd_en at N -> o_valid at N+2.
REQ-020 With i_empty=0 and i_ready=1 held, sustained throughput SHALL be one beat per cycle.
REQ-021 Occupancy SHALL never exceed 4; overflow and FIFO underflow reads are impossible by REQ-014.
REQ-022 An 8-bit beat counter SHALL increment on each handshake and wrap to 0 after PKT_LEN-1; o_last SHALL be 1 when o_valid=1 and counter == PKT_LEN-1.

Reset
REQ-023 While i_rst=1, o_rd_en SHALL be 0 combinationally.
REQ-024 At a clock edge with i_rst=1: pointers, occupancy, in_flight, beat counter SHALL be 0; storage SHALL be cleared so o_data=0, o_valid=0, o_last=0.
REQ-025 Reset mid-operation SHALL discard buffered and in-flight words; the in-flight FIFO word is lost, not written after reset.

Configuration
REQ-026 With macro FIFO_RD_STREAM_CNT_EN defined, the block SHALL add port o_count  output  16  count of accepted beats, reset to 0, +1 per handshake, wrapping 0xFFFF->0x0000.
REQ-027 Without FIFO_RD_STREAM_CNT_EN, o_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-028 Bench SHALL cover first word: FIFO holds 0x01, i_ready=1 -> o_rd_en one cycle, o_valid at N+2 with o_data=0x01, then o_valid=0.
REQ-029 Bench SHALL cover streaming: 32 words 0x01..0x20 written, i_ready=1 -> 32 consecutive beats in order, o_last on 0x10 and 0x20.
REQ-030 Bench SHALL cover backpressure: i_ready=0 with FIFO non-empty -> exactly 4 pops, o_rd_en then 0, o_data held; i_ready=1 -> 4 buffered words in order, pops resume.
REQ-031 Bench SHALL cover alternating i_ready (1,0,1,0...) over 20 words -> no loss, no duplication, pointer wrap exercised.
REQ-032 Bench SHALL cover reset mid-stream: i_rst=1 for 1 cycle with 3 buffered + 1 in flight -> o_valid=0, o_count=0, next word out is the FIFO's next unread word.
REQ-033 Bench SHALL cover empty FIFO: i_empty=1 for 10 cycles -> o_rd_en=0, o_valid=0 throughout.
